vga_scanout_reader: RTL

VGA_SCANOUT_READER -- requirements
Module: vga_scanout_reader

---
 rtl/vga_scanout_reader_pkg.sv | 44 ++++
 rtl/vga_scanout_reader_if.sv | 12 +
 rtl/vga_timing_gen.sv | 39 +++
 rtl/vga_scanout_reader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/vga_scanout_reader_pkg.sv
// Shared 640x480@60 timing constants, cell geometry and address packing for the VGA scanout reader.
package vga_scanout_reader_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COUNT_W    = 10;
  localparam int CELL_COLS  = 20;
  localparam int CELL_ROWS  = 30;
  localparam int CELL_COL_W = 5;
  localparam int CELL_ROW_W = 5;
  localparam int ADDR_W     = CELL_ROW_W + CELL_COL_W;
  localparam int RGB_W      = 3;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  typedef struct packed {
    logic   valid;
    count_t col;
    count_t row;
    logic   hsync;
    logic   vsync;
    logic   vblank;
    logic   visible;
  } pix_info_t;

  // A cell is 32x16 pixels, so the cell coordinates are just the upper counter bits.
  function automatic addr_t cell_addr(input logic [CELL_ROW_W-1:0] cell_row,
                                      input logic [CELL_COL_W-1:0] cell_col);
    return {cell_row, cell_col};
  endfunction

endpackage

// File: rtl/vga_scanout_reader_if.sv
// Video-memory read bus between the scanout reader (master) and the memory (slave).
interface vga_scanout_reader_if;
  import vga_scanout_reader_pkg::*;

  rgb_t  iPixelData;
  addr_t oReadAddress;
  logic  oReadEnable;

  modport master (input iPixelData, output oReadAddress, output oReadEnable);
  modport slave  (output iPixelData, input oReadAddress, input oReadEnable);

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters at half the clock rate with sync, visible and blanking decode.
module vga_timing_gen
  import vga_scanout_reader_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  output logic   pix_en,
  output count_t col,
  output count_t row,
  output logic   hsync,
  output logic   vsync,
  output logic   visible,
  output logic   vblank
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (col == COUNT_W'(H_TOTAL - 1)) begin
          col <= '0;
          row <= (row == COUNT_W'(V_TOTAL - 1)) ? '0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  assign hsync   = !((col >= COUNT_W'(H_ACTIVE + H_FP)) && (col < COUNT_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync   = !((row >= COUNT_W'(V_ACTIVE + V_FP)) && (row < COUNT_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign visible = (col < COUNT_W'(H_ACTIVE)) && (row < COUNT_W'(V_ACTIVE));
  assign vblank  = (row >= COUNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_scanout_reader.sv
// VGA scanout reader: fetches 32x16-pixel cells from video memory and drives registered RGB/sync.
// Define SCANOUT_LINEBUF_EN to fetch each cell-row once into a 20-entry line buffer during h-blank.
module vga_scanout_reader
  import vga_scanout_reader_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  vga_scanout_reader_if.master mem,
  output logic                 oHorizontalSync,
  output logic                 oVerticalSync,
  output logic                 oRed,
  output logic                 oGreen,
  output logic                 oBlue,
  output count_t               oColumnCount,
  output count_t               oRowCount,
  output logic                 oVBlank,
  output logic                 oFrameStart
);

  logic      pix_en;
  logic      hsync;
  logic      vsync;
  logic      visible;
  logic      vblank;
  count_t    col;
  count_t    row;
  pix_info_t s1;
  rgb_t      rgb;

  vga_timing_gen u_timing (
    .clk     (Clock),
    .rst_n   (Reset),
    .pix_en  (pix_en),
    .col     (col),
    .row     (row),
    .hsync   (hsync),
    .vsync   (vsync),
    .visible (visible),
    .vblank  (vblank)
  );

`ifdef SCANOUT_LINEBUF_EN
  // Fetch window starts at column 672 (cell 21) so no fetch overlaps a visible output pixel.
  localparam logic [CELL_COL_W-1:0] FILL_CELL = 5'd21;

  rgb_t                  line_buf [CELL_COLS];
  logic                  s1_fill;
  logic [CELL_COL_W-1:0] s1_idx;
  logic                  load_line;
  logic                  fill_win;
  logic [CELL_ROW_W-1:0] fill_row;

  assign load_line = (row[3:0] == 4'hF) || (row == COUNT_W'(V_TOTAL - 1));
  assign fill_row  = (row == COUNT_W'(V_TOTAL - 1)) ? '0 : row[8:4] + 5'd1;
  assign fill_win  = load_line && (col[9:5] == FILL_CELL) && (col[4:0] < 5'(CELL_COLS));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem.oReadEnable  <= 1'b0;
      mem.oReadAddress <= '0;
      s1_fill          <= 1'b0;
      s1_idx           <= '0;
      for (int i = 0; i < CELL_COLS; i++) line_buf[i] <= '0;
    end else if (!pix_en) begin
      mem.oReadEnable <= fill_win;
      if (fill_win) mem.oReadAddress <= cell_addr(fill_row, col[4:0]);
      if (s1_fill) line_buf[s1_idx] <= mem.iPixelData;
    end else begin
      mem.oReadEnable <= 1'b0;
      s1_fill         <= mem.oReadEnable;
      s1_idx          <= mem.oReadAddress[CELL_COL_W-1:0];
    end
  end

  assign rgb = s1.visible ? line_buf[s1.col[9:5]] : '0;
`else
  // One read per visible pixel; the data returns just in time for the output register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem.oReadEnable  <= 1'b0;
      mem.oReadAddress <= '0;
    end else if (!pix_en) begin
      mem.oReadEnable <= visible;
      if (visible) mem.oReadAddress <= cell_addr(row[8:4], col[9:5]);
    end else begin
      mem.oReadEnable <= 1'b0;
    end
  end

  assign rgb = s1.visible ? mem.iPixelData : '0;
`endif

  // Pixel info is staged one clock so syncs and counts line up with the returning colour.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1              <= '0;
      oHorizontalSync <= 1'b1;
      oVerticalSync   <= 1'b1;
      oRed            <= 1'b0;
      oGreen          <= 1'b0;
      oBlue           <= 1'b0;
      oColumnCount    <= '0;
      oRowCount       <= '0;
      oVBlank         <= 1'b0;
      oFrameStart     <= 1'b0;
    end else if (pix_en) begin
      s1 <= '{valid: 1'b1, col: col, row: row, hsync: hsync, vsync: vsync,
              vblank: vblank, visible: visible};
      oFrameStart <= 1'b0;
    end else if (s1.valid) begin
      oHorizontalSync <= s1.hsync;
      oVerticalSync   <= s1.vsync;
      {oRed, oGreen, oBlue} <= rgb;
      oColumnCount    <= s1.col;
      oRowCount       <= s1.row;
      oVBlank         <= s1.vblank;
      oFrameStart     <= (s1.col == '0) && (s1.row == '0);
    end
  end

endmodule
